// File: rtl/vga_timing_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package  : vga_timing_pkg
// Purpose  : Shared timing defaults (640x480@60 from a 100 MHz clock), sync
//            polarity constants and small helpers for axis totals and
//            counter widths used by the VGA timing controller.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

  // Sync polarity encodings: the value driven while the sync is active.
  localparam bit SYNC_ACTIVE_LOW  = 1'b0;
  localparam bit SYNC_ACTIVE_HIGH = 1'b1;

  // Default 640x480@60 timing, 25 MHz pixel rate from a 100 MHz clock.
  localparam int unsigned DEF_CLK_DIV  = 4;
  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  // Length of one axis period: visible + front porch + sync + back porch.
  function automatic int unsigned axis_total(input int unsigned active,
                                             input int unsigned fp,
                                             input int unsigned sync,
                                             input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  // Pixels per line.
  function automatic int unsigned h_total(input int unsigned active,
                                          input int unsigned fp,
                                          input int unsigned sync,
                                          input int unsigned bp);
    return axis_total(active, fp, sync, bp);
  endfunction

  // Lines per frame.
  function automatic int unsigned v_total(input int unsigned active,
                                          input int unsigned fp,
                                          input int unsigned sync,
                                          input int unsigned bp);
    return axis_total(active, fp, sync, bp);
  endfunction

  // Bits needed to hold the values 0..total-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned total);
    return (total <= 2) ? 1 : $clog2(total);
  endfunction

  // Default width; the line is the longer axis in the default mode.
  localparam int unsigned DEF_CNT_W =
    cnt_width(h_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP));

endpackage
`default_nettype wire

// File: rtl/vga_timing_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface: vga_timing_ctrl_if
// Purpose  : Timing bundle from the VGA sequencer to the colour stage and the
//            tank/sprite ROM address logic.
// Signals  : pix_tick      - one-clk pixel advance strobe
//            hsync/vsync   - sync outputs at the configured polarity
//            colour_enable - high inside the visible area
//            pixel_x/y     - current horizontal / vertical position
//            line_start    - pulse on the tick entering pixel_x = 0
//            frame_start   - pulse on the tick entering (0,0)
//            master = sequencer side, slave = consumer side
// Revision : 1.0 - initial release
// ============================================================================
interface vga_timing_ctrl_if
  import vga_timing_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) ();

  logic             pix_tick;
  logic             hsync;
  logic             vsync;
  logic             colour_enable;
  logic [CNT_W-1:0] pixel_x;
  logic [CNT_W-1:0] pixel_y;
  logic             line_start;
  logic             frame_start;

  modport master (
    output pix_tick, hsync, vsync, colour_enable,
    output pixel_x, pixel_y, line_start, frame_start
  );

  modport slave (
    input pix_tick, hsync, vsync, colour_enable,
    input pixel_x, pixel_y, line_start, frame_start
  );

endinterface
`default_nettype wire

// File: rtl/vga_timing_ctrl_axis_counter.sv
`default_nettype none
// ============================================================================
// Module   : vga_axis_counter
// Purpose  : One display axis: a wrapping position counter plus registered
//            visible and sync decodes. The decodes are computed from the
//            next count so they stay cycle-aligned with the count itself.
// Ports    : clk     - system clock
//            resetn  - synchronous reset, active-low
//            advance - step the count by one (wraps after the last position)
//            count   - current position
//            wrap    - count is at its last position (next advance wraps)
//            visible - count is inside the active region
//            sync    - sync level, POL while in the sync region
// Revision : 1.0 - initial release
// ============================================================================
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned FP     = DEF_H_FP,
  parameter int unsigned SYNC   = DEF_H_SYNC,
  parameter int unsigned BP     = DEF_H_BP,
  parameter bit          POL    = SYNC_ACTIVE_LOW,
  parameter int unsigned W      = DEF_CNT_W
) (
  input  wire logic         clk,
  input  wire logic         resetn,
  input  wire logic         advance,
  output logic [W-1:0]      count,
  output logic              wrap,
  output logic              visible,
  output logic              sync
);

  localparam int unsigned c_total = axis_total(ACTIVE, FP, SYNC, BP);
  localparam logic [W-1:0] c_last = W'(c_total - 1);
  // Region bounds carry one spare bit so an end bound equal to the period
  // length cannot truncate to zero.
  localparam logic [W:0] c_active   = (W+1)'(ACTIVE);
  localparam logic [W:0] c_sync_beg = (W+1)'(ACTIVE + FP);
  localparam logic [W:0] c_sync_end = (W+1)'(ACTIVE + FP + SYNC);

  logic [W-1:0] r_count;
  logic         r_visible;
  logic         r_sync;
  logic [W-1:0] w_next;
  logic [W:0]   w_next_ext;

  assign wrap = (r_count == c_last);

  always_comb begin
    w_next = r_count;
    if (advance) begin
      w_next = wrap ? '0 : r_count + 1'b1;
    end
  end

  assign w_next_ext = {1'b0, w_next};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_count   <= '0;
      r_visible <= 1'b0;
      r_sync    <= ~POL;
    end else begin
      r_count   <= w_next;
      r_visible <= (w_next_ext < c_active);
      r_sync    <= ((w_next_ext >= c_sync_beg) && (w_next_ext < c_sync_end)) ? POL : ~POL;
    end
  end

  assign count   = r_count;
  assign visible = r_visible;
  assign sync    = r_sync;

endmodule
`default_nettype wire

// File: rtl/vga_timing_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_ctrl
// Purpose  : VGA timing sequencer: pixel-rate divider, horizontal/vertical
//            position counters, sync generation, visible-area enable and
//            line/frame start strobes.
// Ports    : clk    - system clock
//            resetn - synchronous reset, active-low
//            vga    - timing bundle (vga_timing_ctrl_if.master)
// Notes    : colour_enable feeds the colour register directly, which delays
//            RGB by one clk relative to the syncs; consumers present colour
//            for pixel_x one clk early or re-register the syncs.
//            Reset itself enters (0,0), so the first frame_start marks the
//            end of frame 0; treat reset as an implicit frame start.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_ctrl
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter bit          SYNC_POL = SYNC_ACTIVE_LOW,
  parameter int unsigned CNT_W    = DEF_CNT_W
) (
  input  wire logic          clk,
  input  wire logic          resetn,
  vga_timing_ctrl_if.master  vga
);

  // w_adv is the pixel advance: counters step on the same edge that
  // registers pix_tick, so pix_tick is high while the new position shows.
  logic w_adv;

  generate
    if (CLK_DIV <= 1) begin : g_div_bypass
      assign w_adv = 1'b1;
    end else begin : g_div_cnt
      localparam int unsigned c_div_w = $clog2(CLK_DIV);
      localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLK_DIV - 1);

      logic [c_div_w-1:0] r_div_cnt;

      always_ff @(posedge clk) begin
        if (!resetn) begin
          r_div_cnt <= '0;
        end else if (r_div_cnt == c_div_last) begin
          r_div_cnt <= '0;
        end else begin
          r_div_cnt <= r_div_cnt + 1'b1;
        end
      end

      assign w_adv = (r_div_cnt == c_div_last);
    end
  endgenerate

  logic [CNT_W-1:0] w_h_count;
  logic [CNT_W-1:0] w_v_count;
  logic             w_h_wrap;
  logic             w_v_wrap;
  logic             w_h_visible;
  logic             w_v_visible;
  logic             w_hsync;
  logic             w_vsync;
  logic             w_v_adv;

  // Lines advance only on the pixel tick that wraps the horizontal count.
  assign w_v_adv = w_adv & w_h_wrap;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POL    (SYNC_POL),
    .W      (CNT_W)
  ) u_h_axis (
    .clk     (clk),
    .resetn  (resetn),
    .advance (w_adv),
    .count   (w_h_count),
    .wrap    (w_h_wrap),
    .visible (w_h_visible),
    .sync    (w_hsync)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POL    (SYNC_POL),
    .W      (CNT_W)
  ) u_v_axis (
    .clk     (clk),
    .resetn  (resetn),
    .advance (w_v_adv),
    .count   (w_v_count),
    .wrap    (w_v_wrap),
    .visible (w_v_visible),
    .sync    (w_vsync)
  );

  logic r_pix_tick;
  logic r_line_start;
  logic r_frame_start;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_pix_tick    <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_pix_tick    <= w_adv;
      r_line_start  <= w_v_adv;
      r_frame_start <= w_v_adv & w_v_wrap;
    end
  end

  assign vga.pix_tick      = r_pix_tick;
  assign vga.hsync         = w_hsync;
  assign vga.vsync         = w_vsync;
  assign vga.colour_enable = w_h_visible & w_v_visible;
  assign vga.pixel_x       = w_h_count;
  assign vga.pixel_y       = w_v_count;
  assign vga.line_start    = r_line_start;
  assign vga.frame_start   = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_ctrl
// Purpose  : Self-checking bench for vga_timing_ctrl. Instance A uses the
//            default line timing with CLK_DIV = 4 and a short frame;
//            instance B uses CLK_DIV = 1 with tiny timing and active-high
//            sync. Both are compared every cycle against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_ctrl;
  import vga_timing_pkg::*;

  localparam int A_DIV = 4, A_HA = 640, A_HFP = 16, A_HS = 96, A_HBP = 48;
  localparam int A_VA = 4, A_VFP = 1, A_VS = 2, A_VBP = 1, A_W = 10;
  localparam bit A_POL = 1'b0;
  localparam int B_DIV = 1, B_HA = 4, B_HFP = 1, B_HS = 1, B_HBP = 1;
  localparam int B_VA = 2, B_VFP = 1, B_VS = 1, B_VBP = 1, B_W = 4;
  localparam bit B_POL = 1'b1;
  localparam int MAX_FAIL = 200;

  typedef struct {
    int cdiv; int ha; int hfp; int hsw; int hbp;
    int va; int vfp; int vsw; int vbp; bit pol;
  } cfg_t;

  typedef struct {
    int div; int h; int v;
    bit tick; bit ce; bit hs; bit vs; bit ls; bit fs;
  } mstate_t;

  typedef struct {
    bit tick; bit ce; bit hs; bit vs; bit ls; bit fs; int x; int y;
  } obs_t;

  typedef struct {
    int per; int hs_n; int vs_n; int ce_n; int ce_bad; int px; int py; obs_t last;
  } meas_t;

  logic clk = 1'b0;
  logic resetn_a, resetn_b;
  int   n_tests = 0;
  int   n_fail  = 0;
  cfg_t cfg_a, cfg_b;
  mstate_t m_a, m_b;
  bit   v_a = 1'b0, v_b = 1'b0;

  always #5 clk = ~clk;

  vga_timing_ctrl_if #(.CNT_W(A_W)) if_a ();
  vga_timing_ctrl_if #(.CNT_W(B_W)) if_b ();

  vga_timing_ctrl #(
    .CLK_DIV(A_DIV), .H_ACTIVE(A_HA), .H_FP(A_HFP), .H_SYNC(A_HS), .H_BP(A_HBP),
    .V_ACTIVE(A_VA), .V_FP(A_VFP), .V_SYNC(A_VS), .V_BP(A_VBP),
    .SYNC_POL(A_POL), .CNT_W(A_W)
  ) u_dut_a (.clk(clk), .resetn(resetn_a), .vga(if_a));

  vga_timing_ctrl #(
    .CLK_DIV(B_DIV), .H_ACTIVE(B_HA), .H_FP(B_HFP), .H_SYNC(B_HS), .H_BP(B_HBP),
    .V_ACTIVE(B_VA), .V_FP(B_VFP), .V_SYNC(B_VS), .V_BP(B_VBP),
    .SYNC_POL(B_POL), .CNT_W(B_W)
  ) u_dut_b (.clk(clk), .resetn(resetn_b), .vga(if_b));

  // Reference: position advances once per CLK_DIV clocks; all outputs are
  // pure functions of the position just entered.
  function automatic mstate_t model_step(input mstate_t s, input cfg_t c, input bit rstn);
    mstate_t n;
    int ht, vt, hsb, vsb;
    ht  = c.ha + c.hfp + c.hsw + c.hbp;
    vt  = c.va + c.vfp + c.vsw + c.vbp;
    hsb = c.ha + c.hfp;
    vsb = c.va + c.vfp;
    n = s;
    if (!rstn) begin
      n.div = 0; n.h = 0; n.v = 0;
      n.tick = 0; n.ce = 0; n.ls = 0; n.fs = 0;
      n.hs = !c.pol; n.vs = !c.pol;
      return n;
    end
    n.tick = (s.div == c.cdiv - 1);
    n.div  = (s.div + 1) % c.cdiv;
    if (n.tick) begin
      n.h = (s.h + 1) % ht;
      if (n.h == 0) n.v = (s.v + 1) % vt;
    end
    n.ls = n.tick && (n.h == 0);
    n.fs = n.ls && (n.v == 0);
    n.ce = (n.h < c.ha) && (n.v < c.va);
    n.hs = (n.h >= hsb && n.h < hsb + c.hsw) ? c.pol : !c.pol;
    n.vs = (n.v >= vsb && n.v < vsb + c.vsw) ? c.pol : !c.pol;
    return n;
  endfunction

  function automatic logic [37:0] pack_m(input mstate_t m);
    return {m.tick, m.ce, m.hs, m.vs, m.ls, m.fs, 16'(m.h), 16'(m.v)};
  endfunction

  function automatic obs_t get_obs(input bit b);
    obs_t o;
    if (b) begin
      o.tick = if_b.pix_tick; o.ce = if_b.colour_enable;
      o.hs = if_b.hsync; o.vs = if_b.vsync;
      o.ls = if_b.line_start; o.fs = if_b.frame_start;
      o.x = int'(if_b.pixel_x); o.y = int'(if_b.pixel_y);
    end else begin
      o.tick = if_a.pix_tick; o.ce = if_a.colour_enable;
      o.hs = if_a.hsync; o.vs = if_a.vsync;
      o.ls = if_a.line_start; o.fs = if_a.frame_start;
      o.x = int'(if_a.pixel_x); o.y = int'(if_a.pixel_y);
    end
    return o;
  endfunction

  task automatic finish_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      if (n_fail >= MAX_FAIL) finish_run();
    end
  endtask

  task automatic check_vec(input string name, input logic [37:0] act, input logic [37:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: dut=%h model=%h ({tick,ce,hs,vs,ls,fs,x16,y16})",
               name, $time, act, exp);
      if (n_fail >= MAX_FAIL) finish_run();
    end
  endtask

  task automatic timeout(input string name, input int budget);
    n_tests++;
    n_fail++;
    $display("FAIL %s: no pulse within %0d cycles", name, budget);
    if (n_fail >= MAX_FAIL) finish_run();
  endtask

  // Counts cycles up to and including the next line/frame pulse, tallying
  // sync-active, visible and out-of-area visible cycles on the way.
  task automatic measure(input bit b, input bit frame, input int budget,
                         input string name, output meas_t r);
    obs_t o;
    bit pol;
    int va;
    pol = b ? B_POL : A_POL;
    va  = b ? B_VA : A_VA;
    r.per = 0; r.hs_n = 0; r.vs_n = 0; r.ce_n = 0; r.ce_bad = 0;
    r.px = -1; r.py = -1;
    while (1) begin
      @(negedge clk);
      o = get_obs(b);
      r.per++;
      if (o.hs == pol) r.hs_n++;
      if (o.vs == pol) r.vs_n++;
      if (o.ce) r.ce_n++;
      if (o.ce && o.y >= va) r.ce_bad++;
      r.last = o;
      if (frame ? o.fs : o.ls) break;
      if (r.per >= budget) begin
        timeout(name, budget);
        break;
      end
      r.px = o.x;
      r.py = o.y;
    end
  endtask

  always @(posedge clk) begin
    m_a <= model_step(m_a, cfg_a, resetn_a);
    m_b <= model_step(m_b, cfg_b, resetn_b);
    if (!resetn_a) v_a <= 1'b1;
    if (!resetn_b) v_b <= 1'b1;
  end

  always @(negedge clk) begin
    if (v_a)
      check_vec("model_a", {if_a.pix_tick, if_a.colour_enable, if_a.hsync, if_a.vsync,
                            if_a.line_start, if_a.frame_start,
                            16'(if_a.pixel_x), 16'(if_a.pixel_y)}, pack_m(m_a));
    if (v_b)
      check_vec("model_b", {if_b.pix_tick, if_b.colour_enable, if_b.hsync, if_b.vsync,
                            if_b.line_start, if_b.frame_start,
                            16'(if_b.pixel_x), 16'(if_b.pixel_y)}, pack_m(m_b));
  end

  initial begin
    #1_500_000;
    timeout("global_watchdog", 150000);
    finish_run();
  end

  initial begin
    obs_t  oa, ob;
    meas_t r;
    int first_a, first_b, x_at_tick, cnt, hold_a, hold_b;
    bit found;

    cfg_a = '{A_DIV, A_HA, A_HFP, A_HS, A_HBP, A_VA, A_VFP, A_VS, A_VBP, A_POL};
    cfg_b = '{B_DIV, B_HA, B_HFP, B_HS, B_HBP, B_VA, B_VFP, B_VS, B_VBP, B_POL};
    resetn_a = 1'b0;
    resetn_b = 1'b0;

    // Reset held for 5 clks: syncs inactive, everything else zero.
    repeat (5) begin
      @(negedge clk);
      oa = get_obs(1'b0);
      ob = get_obs(1'b1);
      check_int("rst_a_ctl", int'({oa.tick, oa.ce, oa.hs, oa.vs, oa.ls, oa.fs}), 6'b001100);
      check_int("rst_a_x", oa.x, 0);
      check_int("rst_a_y", oa.y, 0);
      check_int("rst_b_ctl", int'({ob.tick, ob.ce, ob.hs, ob.vs, ob.ls, ob.fs}), 6'b000000);
    end
    resetn_a = 1'b1;
    resetn_b = 1'b1;

    first_a = -1;
    first_b = -1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      oa = get_obs(1'b0);
      ob = get_obs(1'b1);
      if (first_a < 0 && oa.tick) first_a = k;
      if (first_b < 0 && ob.tick) first_b = k;
    end
    check_int("first_tick_a", first_a, 4);
    check_int("first_tick_b", first_b, 1);

    // CLK_DIV = 1: tick never drops, 7-clk lines, 35-clk frames.
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      ob = get_obs(1'b1);
      if (ob.tick) cnt++;
    end
    check_int("b_tick_cont", cnt, 40);
    measure(1'b1, 1'b0, 20, "b_ls_sync", r);
    measure(1'b1, 1'b0, 20, "b_ls_period", r);
    check_int("b_line_period", r.per, 7);
    measure(1'b1, 1'b1, 50, "b_fs_sync", r);
    check_int("b_corner_prev_x", r.px, 6);
    check_int("b_corner_prev_y", r.py, 4);
    check_int("b_corner_xy", r.last.x * 1000 + r.last.y, 0);
    check_int("b_corner_ls_ce", int'({r.last.ls, r.last.ce}), 2'b11);
    measure(1'b1, 1'b1, 50, "b_fs_period", r);
    check_int("b_frame_period", r.per, 35);
    check_int("b_hsync_active", r.hs_n, 5);
    check_int("b_vsync_active", r.vs_n, 7);
    check_int("b_ce_count", r.ce_n, 8);
    check_int("b_ce_outside", r.ce_bad, 0);

    // Default line timing at CLK_DIV = 4.
    measure(1'b0, 1'b0, 4000, "a_ls_sync", r);
    measure(1'b0, 1'b0, 4000, "a_ls_period", r);
    check_int("a_line_period", r.per, 3200);
    check_int("a_hsync_low", r.hs_n, 384);
    check_int("a_ce_line", r.ce_n, 2560);

    // End of frame 0: wrap corner (799,7) -> (0,0).
    measure(1'b0, 1'b1, 30000, "a_fs_sync", r);
    check_int("a_corner_prev_x", r.px, 799);
    check_int("a_corner_prev_y", r.py, 7);
    check_int("a_corner_xy", r.last.x * 1000 + r.last.y, 0);
    check_int("a_corner_ls_ce_fs", int'({r.last.ls, r.last.ce, r.last.fs}), 3'b111);
    check_int("a_model_pin", int'({m_a.fs, m_a.ce}) * 1000 + m_a.h, 3000);
    measure(1'b0, 1'b1, 30000, "a_fs_period", r);
    check_int("a_frame_period", r.per, 25600);
    check_int("a_vsync_low", r.vs_n, 6400);
    check_int("a_ce_frame", r.ce_n, 10240);
    check_int("a_ce_outside", r.ce_bad, 0);

    // Reset mid-frame at (300,3).
    found = 1'b0;
    for (int k = 0; k < 15000 && !found; k++) begin
      @(negedge clk);
      oa = get_obs(1'b0);
      if (oa.x == 300 && oa.y == 3) found = 1'b1;
    end
    if (!found) timeout("a_mid_wait", 15000);
    resetn_a = 1'b0;
    @(negedge clk);
    oa = get_obs(1'b0);
    check_int("a_mid_rst_ctl", int'({oa.tick, oa.ce, oa.hs, oa.vs, oa.ls, oa.fs}), 6'b001100);
    check_int("a_mid_rst_xy", oa.x * 1000 + oa.y, 0);
    repeat (2) @(negedge clk);
    resetn_a = 1'b1;
    first_a = -1;
    x_at_tick = -1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      oa = get_obs(1'b0);
      if (first_a < 0 && oa.tick) begin
        first_a = k;
        x_at_tick = oa.x * 1000 + oa.y;
      end
    end
    check_int("a_mid_first_tick", first_a, 4);
    check_int("a_mid_first_xy", x_at_tick, 1000);

    // Random reset pulses; the per-cycle model compare checks everything.
    hold_a = 0;
    hold_b = 0;
    repeat (8000) begin
      @(negedge clk);
      if (hold_a > 0) hold_a--;
      else if ($urandom_range(999, 0) < 2) hold_a = $urandom_range(4, 1);
      if (hold_b > 0) hold_b--;
      else if ($urandom_range(999, 0) < 30) hold_b = $urandom_range(4, 1);
      resetn_a = (hold_a == 0);
      resetn_b = (hold_b == 0);
    end
    resetn_a = 1'b1;
    resetn_b = 1'b1;
    repeat (10) @(negedge clk);
    finish_run();
  end

endmodule
`default_nettype wire
